mat_stream_loader: RTL and testbench

Upstream stage of the single-channel max-pool unit. Accepts FP32 feature-map elements one per cycle over a valid/ready stream in raster order and assembles them into a MAT_DIMENSION x MAT_DIMENSION register matrix. Presents the full matrix to the pool, pulses the pool's start/reset, and waits for the pool's `finished`. Only then does it accept the next frame.

---
 rtl/mat_stream_loader_if.sv | 28 ++
 rtl/mat_stream_loader.sv | 124 ++++++++++++
 tb/tb_mat_stream_loader.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_stream_loader_if.sv
// Stream-in / matrix-out bundle between the element source, mat_stream_loader and the max-pool.
// The master side is the element source plus pool; the slave side is the loader.
interface mat_stream_loader_if #(
    parameter int DATAWIDTH     = 32,
    parameter int MAT_DIMENSION = 5,
    parameter int CNT_WIDTH     = 16
);
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] mat_out [MAT_DIMENSION][MAT_DIMENSION];
    logic                 mat_valid;
    logic                 pool_start;
    logic                 pool_finished;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic                 err;

    modport master (
        output in_data, in_valid, in_last, pool_finished,
        input  in_ready, mat_out, mat_valid, pool_start, frame_cnt, err
    );

    modport slave (
        input  in_data, in_valid, in_last, pool_finished,
        output in_ready, mat_out, mat_valid, pool_start, frame_cnt, err
    );
endinterface

// File: rtl/mat_stream_loader.sv
// Assembles a raster-order FP32 stream into a square matrix, starts the max-pool and waits for it.
// Optional macro RELU_EN: negative-signed elements are stored as zero at capture.
module mat_stream_loader #(
    parameter int DATAWIDTH     = 32,
    parameter int MAT_DIMENSION = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic               clk,
    input  logic               rst,
    mat_stream_loader_if.slave bus
);
    localparam int IW = (MAT_DIMENSION > 1) ? $clog2(MAT_DIMENSION) : 1;
    localparam logic [IW-1:0] LAST = IW'(MAT_DIMENSION - 1);

    typedef enum logic [1:0] {S_FILL, S_START, S_WAIT} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IW-1:0]        r_row;
    logic [IW-1:0]        r_col;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic                 r_err;
    logic                 w_in_ready;
    logic                 w_mat_valid;
    logic                 w_pool_start;
    logic                 w_xfer;
    logic                 w_final;
    logic [DATAWIDTH-1:0] w_capture;

    assign w_xfer  = bus.in_valid & w_in_ready;
    assign w_final = (r_row == LAST) && (r_col == LAST);

`ifdef RELU_EN
    assign w_capture = bus.in_data[DATAWIDTH-1] ? '0 : bus.in_data;
`else
    assign w_capture = bus.in_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A finished seen during START is stale from the previous frame, so only WAIT honours it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:  if (w_xfer && w_final) w_state_next = S_START;
            S_START: w_state_next = S_WAIT;
            S_WAIT:  if (bus.pool_finished) w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    always_comb begin
        w_in_ready   = 1'b0;
        w_mat_valid  = 1'b0;
        w_pool_start = 1'b0;
        case (r_state)
            S_FILL:  w_in_ready = 1'b1;
            S_START: begin
                w_mat_valid  = 1'b1;
                w_pool_start = 1'b1;
            end
            S_WAIT:  w_mat_valid = 1'b1;
            default: w_in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row       <= '0;
            r_col       <= '0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (r_col == LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                // in_last must coincide exactly with the final element of the frame.
                if (bus.in_last != w_final) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_WAIT && bus.pool_finished) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < MAT_DIMENSION; gi++) begin : g_row
            for (gj = 0; gj < MAT_DIMENSION; gj++) begin : g_col
                localparam logic [IW-1:0] ROW = IW'(gi);
                localparam logic [IW-1:0] COL = IW'(gj);
                logic [DATAWIDTH-1:0] r_elem;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_elem <= '0;
                    end else if (w_xfer && r_row == ROW && r_col == COL) begin
                        r_elem <= w_capture;
                    end
                end

                assign bus.mat_out[gi][gj] = r_elem;
            end
        end
    endgenerate

    assign bus.in_ready   = w_in_ready;
    assign bus.mat_valid  = w_mat_valid;
    assign bus.pool_start = w_pool_start;
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_mat_stream_loader.sv
// Scoreboard bench for mat_stream_loader: accepted elements are queued and matched against mat_out per frame.
module tb_mat_stream_loader;
    localparam int DW = 32;
    localparam int MD = 5;
    localparam int CW = 16;
    localparam int NE = MD * MD;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int frame_no = 0;
    int start_seen = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] frame_vals [NE];
    logic [DW-1:0] last_frame [MD][MD];
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_err = 1'b0;

    mat_stream_loader_if #(.DATAWIDTH(DW), .MAT_DIMENSION(MD), .CNT_WIDTH(CW)) sif ();

    mat_stream_loader #(.DATAWIDTH(DW), .MAT_DIMENSION(MD), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && sif.pool_start) start_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fp_int(input int v);
        case (v)
            0: fp_int = 32'h00000000;
            1: fp_int = 32'h3f800000;
            2: fp_int = 32'h40000000;
            3: fp_int = 32'h40400000;
            4: fp_int = 32'h40800000;
            5: fp_int = 32'h40a00000;
            6: fp_int = 32'h40c00000;
            7: fp_int = 32'h40e00000;
            default: fp_int = 32'h41000000;
        endcase
    endfunction

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef RELU_EN
        stored = d[DW-1] ? '0 : d;
`else
        stored = d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_ramp();
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                frame_vals[r*MD + c] = fp_int(r + c);
    endtask

    // Drives one element; the expected stored value is queued only when the handshake completes.
    task automatic send_elem(input logic [DW-1:0] d, input logic last);
        int guard = 0;
        bit sent = 0;
        sif.in_data  = d;
        sif.in_valid = 1'b1;
        sif.in_last  = last;
        while (!sent) begin
            if (sif.in_ready) begin
                exp_q.push_back(stored(d));
                sent = 1;
            end
            tick();
            guard++;
            if (!sent && guard > 20) begin
                n_vec++; n_err++;
                $display("FAIL send_elem: in_ready stayed 0 for %0d cycles, required 1", guard);
                break;
            end
        end
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int last_idx, input bit gaps);
        start_seen = 0;
        for (int k = 0; k < NE; k++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
                    sif.in_valid = 1'b0;
                    sif.in_data  = 32'hdeadbeef;
                    sif.in_last  = 1'b1;
                    tick();
                end
            end
            send_elem(frame_vals[k], k == last_idx);
            if (k != last_idx && k == NE - 1) exp_err = 1'b1;
            if (k == last_idx && k != NE - 1) begin
                exp_err = 1'b1;
                n_vec++;
                if (sif.err !== 1'b1) begin
                    n_err++;
                    $display("FAIL early_last_err: err=%b after element %0d, required 1", sif.err, k + 1);
                end
            end
        end
    endtask

    // Called in the START cycle: checks the control outputs and drains the scoreboard against mat_out.
    task automatic check_start_and_frame();
        int bad = 0;
        n_vec++;
        if (sif.in_ready !== 1'b0 || sif.mat_valid !== 1'b1 || sif.pool_start !== 1'b1) begin
            n_err++;
            $display("FAIL start_cycle: in_ready=%b mat_valid=%b pool_start=%b, required 0 1 1",
                     sif.in_ready, sif.mat_valid, sif.pool_start);
        end
        n_vec++;
        if (exp_q.size() != NE) begin
            n_err++;
            $display("FAIL scoreboard_depth: %0d queued, required %0d", exp_q.size(), NE);
        end
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                logic [DW-1:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                last_frame[r][c] = e;
                n_vec++;
                if (sif.mat_out[r][c] !== e) begin
                    n_err++; bad++;
                    $display("FAIL mat_out[%0d][%0d]: got %h, required %h", r, c, sif.mat_out[r][c], e);
                end
            end
        end
        frame_no++;
        $display("frame %0d: %0d elements compared, %0d wrong", frame_no, NE, bad);
    endtask

    task automatic finish_frame(input bit pulse_in_start, input bit hold_valid);
        int bad = 0;
        sif.pool_finished = pulse_in_start;
        tick();
        sif.pool_finished = 1'b0;
        n_vec++;
        if (sif.in_ready !== 1'b0 || sif.mat_valid !== 1'b1 || sif.pool_start !== 1'b0) begin
            n_err++;
            $display("FAIL wait_cycle: in_ready=%b mat_valid=%b pool_start=%b, required 0 1 0",
                     sif.in_ready, sif.mat_valid, sif.pool_start);
        end
        if (hold_valid) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 32'h12345678;
            for (int i = 0; i < 10; i++) begin
                tick();
                n_vec++;
                if (sif.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_in_ready: in_ready=%b in WAIT cycle %0d, required 0", sif.in_ready, i);
                end
            end
            sif.in_valid = 1'b0;
            for (int r = 0; r < MD; r++)
                for (int c = 0; c < MD; c++)
                    if (sif.mat_out[r][c] !== last_frame[r][c]) bad++;
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL hold_mat_out: %0d elements changed while waiting, required 0", bad);
            end
        end
        repeat (3) tick();
        sif.pool_finished = 1'b1;
        tick();
        sif.pool_finished = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        n_vec++;
        if (sif.in_ready !== 1'b1 || sif.mat_valid !== 1'b0) begin
            n_err++;
            $display("FAIL after_finished: in_ready=%b mat_valid=%b, required 1 0", sif.in_ready, sif.mat_valid);
        end
        n_vec++;
        if (sif.frame_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL frame_cnt: got %0d, required %0d", sif.frame_cnt, exp_cnt);
        end
        n_vec++;
        if (sif.err !== exp_err) begin
            n_err++;
            $display("FAIL err: got %b, required %b", sif.err, exp_err);
        end
        n_vec++;
        if (start_seen != 1) begin
            n_err++;
            $display("FAIL pool_start_count: %0d pulses this frame, required 1", start_seen);
        end
    endtask

    task automatic check_cleared(input string tag);
        int nz = 0;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                if (sif.mat_out[r][c] !== '0) nz++;
        n_vec++;
        if (nz != 0) begin
            n_err++;
            $display("FAIL %s_mat_out: %0d nonzero elements, required 0", tag, nz);
        end
        n_vec++;
        if (sif.mat_valid !== 1'b0 || sif.pool_start !== 1'b0 || sif.frame_cnt !== '0 || sif.err !== 1'b0) begin
            n_err++;
            $display("FAIL %s_outputs: mat_valid=%b pool_start=%b frame_cnt=%0d err=%b, required 0 0 0 0",
                     tag, sif.mat_valid, sif.pool_start, sif.frame_cnt, sif.err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        check_cleared("reset");
        rst = 1'b1;
        tick();
        n_vec++;
        if (sif.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, required 1", sif.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        load_ramp();
        send_frame(NE - 1, 1'b0);
        check_start_and_frame();
        n_vec++;
        if (sif.mat_out[MD-1][MD-1] !== 32'h41000000) begin
            n_err++;
            $display("FAIL corner: mat_out[4][4]=%h, required 41000000", sif.mat_out[MD-1][MD-1]);
        end
        finish_frame(1'b0, 1'b0);
    endtask

    task automatic test_random_valid();
        load_ramp();
        send_frame(NE - 1, 1'b1);
        check_start_and_frame();
        finish_frame(1'b0, 1'b0);
    endtask

    task automatic test_hold_off();
        for (int k = 0; k < NE; k++) frame_vals[k] = 32'h3f000000 + k;
        send_frame(NE - 1, 1'b0);
        check_start_and_frame();
        finish_frame(1'b1, 1'b1);
    endtask

    task automatic test_framing();
        load_ramp();
        send_frame(9, 1'b0);
        check_start_and_frame();
        finish_frame(1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        load_ramp();
        for (int k = 0; k < 12; k++) send_elem(frame_vals[k], 1'b0);
        rst = 1'b0;
        #1;
        check_cleared("midreset");
        exp_q.delete();
        exp_cnt = '0;
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_frame(NE - 1, 1'b0);
        check_start_and_frame();
        finish_frame(1'b0, 1'b0);
    endtask

    task automatic test_relu();
        load_ramp();
        frame_vals[0]          = 32'h80000000;
        frame_vals[2*MD + 2]   = 32'hc0800000;
        frame_vals[4*MD + 0]   = 32'hff800001;
        send_frame(NE - 1, 1'b0);
        check_start_and_frame();
        finish_frame(1'b0, 1'b0);
    endtask

    initial begin
        sif.in_data       = '0;
        sif.in_valid      = 1'b0;
        sif.in_last       = 1'b0;
        sif.pool_finished = 1'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_random_valid();
        test_hold_off();
        test_framing();
        test_mid_reset();
        test_relu();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
